// File: rtl/booth_mul_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_stream_ctrl_if
// Brief    : Operand-in / product-out valid-ready stream bundle.
// Revision : 1.0
// ============================================================================
interface booth_mul_stream_ctrl_if #(
  parameter int LENGTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [LENGTH-1:0]     s_a;
  logic [LENGTH-1:0]     s_b;
  logic                  m_valid;
  logic                  m_ready;
  logic [2*LENGTH-1:0]   m_p;

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_p
  );

  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_p
  );
endinterface
`default_nettype wire

// File: rtl/booth_mul_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_stream_ctrl
// Brief    : Credit-based stream controller around a fixed-latency pipelined
//            signed Booth multiplier. Optional counters: BOOTH_STREAM_STATS_EN.
// Revision : 1.0
// ============================================================================
module booth_mul_stream_ctrl #(
  parameter int LENGTH     = 32,
  parameter int MUL_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic                 sys_clk,
  input  wire logic                 sys_rst_n,
  booth_mul_stream_ctrl_if.slave    strm,
  output logic [LENGTH-1:0]         mul_a,
  output logic [LENGTH-1:0]         mul_b,
  input  wire logic [2*LENGTH-1:0]  mul_p,
  input  wire logic                 flush_req,
  output logic                      flush_done,
  output logic                      busy
`ifdef BOOTH_STREAM_STATS_EN
  ,
  output logic [31:0]               op_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                r_state;
  logic [MUL_LAT-1:0]    r_vpipe;
  logic [2*LENGTH-1:0]   r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]       r_wr_ptr;
  logic [c_aw-1:0]       r_rd_ptr;
  logic [c_cw-1:0]       r_fcnt;
  logic [c_cw-1:0]       r_cnt;
  logic                  r_s_ready;
  logic                  r_m_valid;
  logic [2*LENGTH-1:0]   r_m_p;
  logic                  r_flush_done;
  logic                  r_busy;

  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [MUL_LAT-1:0]    w_vpipe_nxt;
  state_t                w_state_nxt;
  logic [c_aw-1:0]       w_wr_ptr_nxt;
  logic [c_aw-1:0]       w_rd_ptr_nxt;
  logic [c_cw-1:0]       w_fcnt_nxt;
  logic [c_cw-1:0]       w_cnt_nxt;
  logic [c_cw-1:0]       w_fill_after_pop;
  logic [2*LENGTH-1:0]   w_head_nxt;
  logic                  w_m_valid_nxt;

  assign mul_a        = strm.s_a;
  assign mul_b        = strm.s_b;
  assign strm.s_ready = r_s_ready;
  assign strm.m_valid = r_m_valid;
  assign strm.m_p     = r_m_p;
  assign flush_done   = r_flush_done;
  assign busy         = r_busy;

  assign w_issue = strm.s_valid & r_s_ready;
  assign w_push  = r_vpipe[MUL_LAT-1];
  assign w_pop   = r_m_valid & strm.m_ready;

  generate
    if (MUL_LAT == 1) begin : g_vpipe_one
      assign w_vpipe_nxt = w_issue;
    end else begin : g_vpipe_shift
      assign w_vpipe_nxt = {r_vpipe[MUL_LAT-2:0], w_issue};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (flush_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_vpipe == '0) w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_wr_ptr_nxt     = r_wr_ptr + c_aw'(w_push);
    w_rd_ptr_nxt     = r_rd_ptr + c_aw'(w_pop);
    w_fcnt_nxt       = r_fcnt + c_cw'(w_push) - c_cw'(w_pop);
    w_cnt_nxt        = r_cnt + c_cw'(w_issue) - c_cw'(w_pop);
    w_fill_after_pop = r_fcnt - c_cw'(w_pop);
    // When the FIFO would be empty after the pop, the only possible new head
    // is the product being written on this very edge.
    w_head_nxt       = (w_fill_after_pop == '0) ? mul_p : r_mem[w_rd_ptr_nxt];
    if (r_state == ST_CLEAR) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_fcnt_nxt   = '0;
      w_cnt_nxt    = '0;
    end
    w_m_valid_nxt = (w_state_nxt != ST_CLEAR) && (w_fcnt_nxt != '0);
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mul_p;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_RUN;
      r_vpipe      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fcnt       <= '0;
      r_cnt        <= '0;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_p        <= '0;
      r_flush_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vpipe      <= w_vpipe_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_fcnt       <= w_fcnt_nxt;
      r_cnt        <= w_cnt_nxt;
      r_s_ready    <= (w_state_nxt == ST_RUN) && (w_cnt_nxt < c_depth);
      r_m_valid    <= w_m_valid_nxt;
      if (w_m_valid_nxt) r_m_p <= w_head_nxt;
      r_flush_done <= (w_state_nxt == ST_CLEAR);
      r_busy       <= (w_cnt_nxt != '0) || (w_state_nxt != ST_RUN);
    end
  end

`ifdef BOOTH_STREAM_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      op_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_pop) op_cnt <= op_cnt + 32'd1;
      if (strm.s_valid && !r_s_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
